// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg7_pkg
// Description : Shared constants and helpers for the 7-segment display
//               engine. Holds the active-low glyph table for the 16 nibble
//               values, the all-segments-off pattern and a lookup function.
//               Segment bit order is {g,f,e,d,c,b,a}; a 0 lights a segment.
// Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    // All segments off (active-low).
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low glyphs for 0-9, A, b, C, d, E, F.
    localparam logic [6:0] c_glyph [16] = '{
        7'h40,  // 0
        7'h79,  // 1
        7'h24,  // 2
        7'h30,  // 3
        7'h19,  // 4
        7'h12,  // 5
        7'h02,  // 6
        7'h78,  // 7
        7'h00,  // 8
        7'h10,  // 9
        7'h08,  // A
        7'h03,  // b
        7'h46,  // C
        7'h21,  // d
        7'h06,  // E
        7'h0E   // F
    };

    // Returns the active-low segment pattern for one nibble.
    function automatic logic [6:0] seg7_glyph(input logic [3:0] nibble);
        return c_glyph[nibble];
    endfunction

endpackage : seg7_pkg
`default_nettype wire

// File: rtl/seg7_scan_timer.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_timer
// Description : Digit-multiplex scan timer. A cycle counter runs
//               0..SCAN_DIV-1; each wrap advances the slot index through
//               0..N_DIGITS-1. The blank flag is set while the counter is
//               below BLANK_CYCLES (anti-ghosting window at slot start).
//
//               The outputs are look-ahead values: they describe the state
//               the timer will hold after the coming clock edge. The parent
//               registers its display outputs from them, so its registered
//               o_sel / segment outputs line up exactly with the timer state.
//
// Ports       : i_clk    in   system clock
//               i_rst    in   asynchronous active-low reset
//               o_slot   out  slot index for the next cycle
//               o_blank  out  blanking flag for the next cycle
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_timer #(
    parameter  int SCAN_DIV     = 50000,
    parameter  int BLANK_CYCLES = 16,
    parameter  int N_DIGITS     = 4,
    localparam int SLOT_W       = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    output logic [SLOT_W-1:0] o_slot,
    output logic              o_blank
);

    localparam int                CNT_W       = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0]  c_cnt_last  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]  c_blank_end = CNT_W'(BLANK_CYCLES);
    localparam logic [SLOT_W-1:0] c_slot_last = SLOT_W'(N_DIGITS - 1);

    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  w_count_next;
    logic [SLOT_W-1:0] r_slot;
    logic [SLOT_W-1:0] w_slot_next;

    always_comb begin
        w_count_next = r_count + CNT_W'(1);
        w_slot_next  = r_slot;
        if (r_count == c_cnt_last) begin
            w_count_next = '0;
            w_slot_next  = (r_slot == c_slot_last) ? '0 : r_slot + SLOT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_count <= '0;
            r_slot  <= '0;
        end else begin
            r_count <= w_count_next;
            r_slot  <= w_slot_next;
        end
    end

    assign o_slot  = w_slot_next;
    assign o_blank = (w_count_next < c_blank_end);

endmodule : seg7_scan_timer
`default_nettype wire

// File: rtl/seg7_scan_counter.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_counter
// Description : N-digit BCD/hex up/down counter with a multiplexed 7-segment
//               display driver. Debounced button pulses increment or
//               decrement individual digit positions with ripple carry and
//               borrow; the value is scanned one digit at a time onto a
//               shared active-low segment bus with a blanking window at the
//               start of each slot and optional leading-zero suppression.
//
// Ports       : i_clk           in   system clock
//               i_rst           in   asynchronous active-low reset
//               i_inc           in   per-digit increment pulses
//               i_dec           in   per-digit decrement pulses
//               i_clear         in   clear-to-zero pulse
//               i_load          in   load pulse
//               i_load_value    in   packed digits to load (digit 0 in [3:0])
//               o_value         out  current packed value
//               o_overflow      out  pulse on increment wrap past maximum
//               o_underflow     out  pulse on decrement wrap below zero
//               o_digitalTube   out  segments {g,f,e,d,c,b,a}, active-low
//               o_sel           out  one-hot active-low digit enables
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_counter
    import seg7_pkg::*;
#(
    parameter int N_DIGITS      = 4,      // 1..8
    parameter int RADIX         = 10,     // 10 or 16
    parameter int SCAN_DIV      = 50000,  // >= 2
    parameter int BLANK_CYCLES  = 16,     // < SCAN_DIV
    parameter int BLANK_LEADING = 0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [N_DIGITS-1:0]   i_inc,
    input  logic [N_DIGITS-1:0]   i_dec,
    input  logic                  i_clear,
    input  logic                  i_load,
    input  logic [4*N_DIGITS-1:0] i_load_value,
    output logic [4*N_DIGITS-1:0] o_value,
    output logic                  o_overflow,
    output logic                  o_underflow,
    output logic [6:0]            o_digitalTube,
    output logic [N_DIGITS-1:0]   o_sel
);

    localparam int         SLOT_W      = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [3:0] c_digit_max = 4'(RADIX - 1);

    // ------------------------------------------------------------------------
    // Counter datapath
    // ------------------------------------------------------------------------
    logic [4*N_DIGITS-1:0] r_value;
    logic [4*N_DIGITS-1:0] w_value_next;
    logic                  r_overflow;
    logic                  r_underflow;
    logic [N_DIGITS-1:0]   w_inc_sel;
    logic [N_DIGITS-1:0]   w_dec_sel;
    logic [N_DIGITS-1:0]   w_suppress;
    logic                  w_carry_out;
    logic                  w_borrow_out;
    logic                  w_do_inc;
    logic                  w_do_dec;

    // Isolate the lowest asserted bit (two's-complement trick).
    assign w_inc_sel = i_inc & (-i_inc);
    assign w_dec_sel = i_dec & (-i_dec);

    // Only one command per cycle: clear > load > inc > dec.
    assign w_do_inc = !i_clear && !i_load && (|i_inc);
    assign w_do_dec = !i_clear && !i_load && !(|i_inc) && (|i_dec);

    for (genvar j = 0; j < N_DIGITS; j++) begin : g_digit
        logic [3:0] w_cur;
        logic [3:0] w_load;
        logic [3:0] w_next;
        logic       w_cin;
        logic       w_bin;
        logic       w_zero_above;

        assign w_cur  = r_value[4*j +: 4];
        assign w_load = (i_load_value[4*j +: 4] > c_digit_max) ? c_digit_max
                                                               : i_load_value[4*j +: 4];

        // Digit j steps when the selected index k <= j and every digit in
        // k..j-1 is at its wrap value (carry) or at zero (borrow).
        always_comb begin
            w_cin = 1'b0;
            w_bin = 1'b0;
            for (int k = 0; k <= j; k++) begin
                w_cin = w_cin | w_inc_sel[k];
                w_bin = w_bin | w_dec_sel[k];
                if (k < j) begin
                    w_cin = w_cin & (r_value[4*k +: 4] == c_digit_max);
                    w_bin = w_bin & (r_value[4*k +: 4] == 4'd0);
                end
            end
        end

        always_comb begin
            w_next = w_cur;
            if (i_clear) begin
                w_next = '0;
            end else if (i_load) begin
                w_next = w_load;
            end else if (|i_inc) begin
                if (w_cin) begin
                    w_next = (w_cur == c_digit_max) ? 4'd0 : w_cur + 4'd1;
                end
            end else if (|i_dec) begin
                if (w_bin) begin
                    w_next = (w_cur == 4'd0) ? c_digit_max : w_cur - 4'd1;
                end
            end
        end

        assign w_value_next[4*j +: 4] = w_next;

        // Suppression looks at the value being registered this edge so the
        // blanking decision matches the digit shown alongside it.
        always_comb begin
            w_zero_above = 1'b1;
            for (int k = j; k < N_DIGITS; k++) begin
                w_zero_above = w_zero_above & (w_value_next[4*k +: 4] == 4'd0);
            end
        end

        assign w_suppress[j] = (BLANK_LEADING != 0) && (j != 0) && w_zero_above;

        if (j == N_DIGITS - 1) begin : g_top_digit
            assign w_carry_out  = w_cin && (w_cur == c_digit_max);
            assign w_borrow_out = w_bin && (w_cur == 4'd0);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_value     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_value     <= w_value_next;
            r_overflow  <= w_do_inc && w_carry_out;
            r_underflow <= w_do_dec && w_borrow_out;
        end
    end

    // ------------------------------------------------------------------------
    // Display scan
    // ------------------------------------------------------------------------
    logic [SLOT_W-1:0]   w_slot_next;
    logic                w_blank_next;
    logic [3:0]          w_digit_shown;
    logic                w_suppress_shown;
    logic [N_DIGITS-1:0] w_sel_next;
    logic [6:0]          w_tube_next;
    logic [N_DIGITS-1:0] r_sel;
    logic [6:0]          r_tube;

    seg7_scan_timer #(
        .SCAN_DIV     (SCAN_DIV),
        .BLANK_CYCLES (BLANK_CYCLES),
        .N_DIGITS     (N_DIGITS)
    ) u_scan_timer (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .o_slot  (w_slot_next),
        .o_blank (w_blank_next)
    );

    always_comb begin
        w_digit_shown    = 4'd0;
        w_suppress_shown = 1'b0;
        for (int j = 0; j < N_DIGITS; j++) begin
            if (w_slot_next == SLOT_W'(j)) begin
                w_digit_shown    = w_value_next[4*j +: 4];
                w_suppress_shown = w_suppress[j];
            end
        end
        w_sel_next  = ~(N_DIGITS'(1) << w_slot_next);
        w_tube_next = (w_blank_next || w_suppress_shown) ? SEG_BLANK
                                                         : seg7_glyph(w_digit_shown);
    end

    // Select and segments share one register stage so they always switch
    // together.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_sel  <= ~N_DIGITS'(1);
            r_tube <= SEG_BLANK;
        end else begin
            r_sel  <= w_sel_next;
            r_tube <= w_tube_next;
        end
    end

    assign o_value       = r_value;
    assign o_overflow    = r_overflow;
    assign o_underflow   = r_underflow;
    assign o_sel         = r_sel;
    assign o_digitalTube = r_tube;

endmodule : seg7_scan_counter
`default_nettype wire

// File: tb/tb_seg7_scan_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_scan_counter
// Description : Directed self-checking bench for seg7_scan_counter with
//               N_DIGITS=4, RADIX=10, SCAN_DIV=8, BLANK_CYCLES=2. Two
//               instances share stimulus: dut0 without and dut1 with
//               leading-zero suppression.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_counter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  inc;
    logic [3:0]  dec;
    logic        clear;
    logic        load;
    logic [15:0] load_value;

    logic [15:0] value0, value1;
    logic        ov0, ov1, un0, un1;
    logic [6:0]  tube0, tube1;
    logic [3:0]  sel0, sel1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seg7_scan_counter #(
        .N_DIGITS(4), .RADIX(10), .SCAN_DIV(8), .BLANK_CYCLES(2), .BLANK_LEADING(0)
    ) dut0 (
        .i_clk(clk), .i_rst(rst_n), .i_inc(inc), .i_dec(dec), .i_clear(clear),
        .i_load(load), .i_load_value(load_value), .o_value(value0),
        .o_overflow(ov0), .o_underflow(un0), .o_digitalTube(tube0), .o_sel(sel0)
    );

    seg7_scan_counter #(
        .N_DIGITS(4), .RADIX(10), .SCAN_DIV(8), .BLANK_CYCLES(2), .BLANK_LEADING(1)
    ) dut1 (
        .i_clk(clk), .i_rst(rst_n), .i_inc(inc), .i_dec(dec), .i_clear(clear),
        .i_load(load), .i_load_value(load_value), .o_value(value1),
        .o_overflow(ov1), .o_underflow(un1), .o_digitalTube(tube1), .o_sel(sel1)
    );

    // Advance one clock; sample point is 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if (value0 !== 16'h0000 || sel0 !== 4'b1110 || tube0 !== 7'h7F) begin
            errors++;
            $display("FAIL reset_initial: value=%h sel=%b tube=%h required 0000 1110 7f",
                     value0, sel0, tube0);
        end
        rst_n = 1'b1;
        load = 1'b1; load_value = 16'h1234;
        tick();
        load = 1'b0;
        checks++;
        if (value0 !== 16'h1234) begin
            errors++;
            $display("FAIL reset_preload: value=%h required 1234", value0);
        end
        repeat (10) tick();
        // Asynchronous assertion away from any clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (value0 !== 16'h0000 || sel0 !== 4'b1110 || tube0 !== 7'h7F) begin
            errors++;
            $display("FAIL reset_async: value=%h sel=%b tube=%h required 0000 1110 7f",
                     value0, sel0, tube0);
        end
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (sel0 !== 4'b1110 || tube0 !== ((i < 2) ? 7'h7F : 7'h40)) begin
                errors++;
                $display("FAIL reset_slot0 cyc=%0d: sel=%b tube=%h required 1110 %h",
                         i, sel0, tube0, (i < 2) ? 7'h7F : 7'h40);
            end
            tick();
        end
        checks++;
        if (sel0 !== 4'b1101 || tube0 !== 7'h7F) begin
            errors++;
            $display("FAIL reset_slot1: sel=%b tube=%h required 1101 7f", sel0, tube0);
        end
    endtask

    task automatic test_carry();
        logic [15:0] exp_vals [10] = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005,
                                       16'h0006, 16'h0007, 16'h0008, 16'h0009, 16'h0010};
        clear = 1'b1;
        tick();
        clear = 1'b0;
        inc = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (value0 !== exp_vals[i] || ov0 !== 1'b0) begin
                errors++;
                $display("FAIL carry_step%0d: value=%h ov=%b required %h 0",
                         i, value0, ov0, exp_vals[i]);
            end
        end
        inc = 4'b0010;
        tick();
        inc = 4'b0000;
        checks++;
        if (value0 !== 16'h0020) begin
            errors++;
            $display("FAIL carry_digit1: value=%h required 0020", value0);
        end
    endtask

    task automatic test_wrap();
        load = 1'b1; load_value = 16'h9999;
        tick();
        load = 1'b0;
        checks++;
        if (value0 !== 16'h9999) begin
            errors++;
            $display("FAIL wrap_load: value=%h required 9999", value0);
        end
        inc = 4'b0001;
        tick();
        inc = 4'b0000;
        checks++;
        if (value0 !== 16'h0000 || ov0 !== 1'b1 || ov1 !== 1'b1 || un0 !== 1'b0) begin
            errors++;
            $display("FAIL wrap_overflow: value=%h ov0=%b ov1=%b un=%b required 0000 1 1 0",
                     value0, ov0, ov1, un0);
        end
        tick();
        checks++;
        if (ov0 !== 1'b0) begin
            errors++;
            $display("FAIL wrap_overflow_pulse: ov=%b required 0", ov0);
        end
        dec = 4'b0001;
        tick();
        dec = 4'b0000;
        checks++;
        if (value0 !== 16'h9999 || un0 !== 1'b1 || un1 !== 1'b1 || ov0 !== 1'b0) begin
            errors++;
            $display("FAIL wrap_underflow: value=%h un0=%b un1=%b ov=%b required 9999 1 1 0",
                     value0, un0, un1, ov0);
        end
        tick();
        checks++;
        if (un0 !== 1'b0) begin
            errors++;
            $display("FAIL wrap_underflow_pulse: un=%b required 0", un0);
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        inc = 4'b0001; dec = 4'b0001;
        tick();
        inc = 4'b0000; dec = 4'b0000;
        checks++;
        if (value0 !== 16'h0001 || un0 !== 1'b0 || ov0 !== 1'b0) begin
            errors++;
            $display("FAIL wrap_inc_over_dec: value=%h un=%b ov=%b required 0001 0 0",
                     value0, un0, ov0);
        end
    endtask

    task automatic test_priority();
        clear = 1'b1; inc = 4'b0001;
        tick();
        clear = 1'b0; inc = 4'b0000;
        checks++;
        if (value0 !== 16'h0000) begin
            errors++;
            $display("FAIL prio_clear_inc: value=%h required 0000", value0);
        end
        inc = 4'b0101;
        tick();
        inc = 4'b0000;
        checks++;
        if (value0 !== 16'h0001) begin
            errors++;
            $display("FAIL prio_lowest_inc: value=%h required 0001", value0);
        end
        load = 1'b1; load_value = 16'h00AF; inc = 4'b0001;
        tick();
        load = 1'b0; inc = 4'b0000;
        checks++;
        if (value0 !== 16'h0099) begin
            errors++;
            $display("FAIL prio_load_saturate: value=%h required 0099", value0);
        end
        dec = 4'b0110;
        tick();
        dec = 4'b0000;
        checks++;
        if (value0 !== 16'h0089) begin
            errors++;
            $display("FAIL prio_lowest_dec: value=%h required 0089", value0);
        end
        load = 1'b1; load_value = 16'h0100;
        tick();
        load = 1'b0;
        dec = 4'b0001;
        tick();
        dec = 4'b0000;
        checks++;
        if (value0 !== 16'h0099 || un0 !== 1'b0) begin
            errors++;
            $display("FAIL prio_borrow_ripple: value=%h un=%b required 0099 0", value0, un0);
        end
    endtask

    task automatic test_back_to_back();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        inc = 4'b0001;
        tick();
        checks++;
        if (value0 !== 16'h0001) begin
            errors++;
            $display("FAIL b2b_first: value=%h required 0001", value0);
        end
        inc = 4'b0010;
        tick();
        checks++;
        if (value0 !== 16'h0011) begin
            errors++;
            $display("FAIL b2b_second: value=%h required 0011", value0);
        end
        inc = 4'b0000; dec = 4'b0001;
        tick();
        dec = 4'b0000;
        checks++;
        if (value0 !== 16'h0010) begin
            errors++;
            $display("FAIL b2b_third: value=%h required 0010", value0);
        end
        load = 1'b1; load_value = 16'h0198;
        tick();
        load = 1'b0; inc = 4'b0001;
        tick();
        tick();
        inc = 4'b0000;
        checks++;
        if (value0 !== 16'h0200) begin
            errors++;
            $display("FAIL b2b_load_inc_inc: value=%h required 0200", value0);
        end
    endtask

    task automatic test_scan_pattern();
        logic [6:0] glyph42 [4] = '{7'h24, 7'h19, 7'h40, 7'h40};
        logic [3:0] exp_sel;
        logic [6:0] exp0;
        logic [6:0] exp1;
        int s;
        int c;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        load = 1'b1; load_value = 16'h0042;
        for (int cyc = 0; cyc < 32; cyc++) begin
            s = cyc / 8;
            c = cyc % 8;
            exp_sel = ~(4'b0001 << s);
            exp0 = (c < 2) ? 7'h7F : glyph42[s];
            exp1 = (c < 2 || s >= 2) ? 7'h7F : glyph42[s];
            checks++;
            if (sel0 !== exp_sel || sel1 !== exp_sel || tube0 !== exp0 || tube1 !== exp1) begin
                errors++;
                $display("FAIL scan_0042 cyc=%0d: sel0=%b sel1=%b tube0=%h tube1=%h required %b %b %h %h",
                         cyc, sel0, sel1, tube0, tube1, exp_sel, exp_sel, exp0, exp1);
            end
            tick();
            load = 1'b0;
        end
        checks++;
        if (sel0 !== 4'b1110 || value0 !== 16'h0042) begin
            errors++;
            $display("FAIL scan_wrap: sel=%b value=%h required 1110 0042", sel0, value0);
        end
    endtask

    task automatic test_leading_zero();
        logic [6:0] exp0;
        logic [6:0] exp1;
        int s;
        int c;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if (value1 !== 16'h0000) begin
            errors++;
            $display("FAIL lz_value: value=%h required 0000", value1);
        end
        for (int cyc = 0; cyc < 32; cyc++) begin
            s = cyc / 8;
            c = cyc % 8;
            exp0 = (c < 2) ? 7'h7F : 7'h40;
            exp1 = (c < 2 || s != 0) ? 7'h7F : 7'h40;
            checks++;
            if (tube0 !== exp0 || tube1 !== exp1) begin
                errors++;
                $display("FAIL lz_zero cyc=%0d: tube0=%h tube1=%h required %h %h",
                         cyc, tube0, tube1, exp0, exp1);
            end
            tick();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        inc = 4'b0000;
        dec = 4'b0000;
        clear = 1'b0;
        load = 1'b0;
        load_value = 16'h0000;
        tick();
        tick();
        test_reset();
        test_carry();
        test_wrap();
        test_priority();
        test_back_to_back();
        test_scan_pattern();
        test_leading_zero();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_seg7_scan_counter
`default_nettype wire
